// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampling asynchronous serial receiver. Validates the start
//            bit at mid-bit, shifts DATA_BITS data bits in LSB-first, checks
//            the stop bit and reports each frame with a one-cycle pulse on
//            data_valid or frame_err.
// Options  : define UART_RX_PARITY_EN to receive one even-parity bit between
//            the last data bit and the stop bit (drives parity_err).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = 8,    // data bits per frame, 2 or more
    parameter int OVERSAMPLE = 16    // sample_tick pulses per bit, even, >= 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS);

    localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_state;
    logic [c_TW-1:0]      r_tick_cnt;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_par_bit;

    logic                 w_rxs;
    logic [2:0]           w_state_nxt;
    logic [c_TW-1:0]      w_tick_nxt;
    logic [c_BW-1:0]      w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_data_out_nxt;
    logic                 w_valid_nxt;
    logic                 w_ferr_nxt;
    logic                 w_perr_nxt;
    logic                 w_par_nxt;

    assign w_rxs = r_sync2;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters, shift register and result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_par_bit    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_valid_nxt;
            r_frame_err  <= w_ferr_nxt;
            r_parity_err <= w_perr_nxt;
            r_par_bit    <= w_par_nxt;
        end
    end

    // Next-state logic; everything except the pulses only moves on a tick
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_nxt     = r_tick_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_data_out_nxt = r_data_out;
        w_valid_nxt    = 1'b0;
        w_ferr_nxt     = 1'b0;
        w_perr_nxt     = 1'b0;
        w_par_nxt      = r_par_bit;
        if (sample_tick) begin
            case (r_state)
                c_IDLE: begin
                    if (!w_rxs) begin
                        w_state_nxt = c_START;
                        w_tick_nxt  = '0;
                    end
                end
                c_START: begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        // A line that is high again by mid start bit was noise
                        if (w_rxs) begin
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_state_nxt = c_DATA;
                            w_tick_nxt  = '0;
                            w_bit_nxt   = '0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = c_PARITY;
`else
                            w_state_nxt = c_STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                c_PARITY: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_nxt  = '0;
                        w_par_nxt   = w_rxs;
                        w_state_nxt = c_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
`endif
                c_STOP: begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        // Leave at mid stop bit so a back-to-back start is caught
                        w_tick_nxt  = '0;
                        w_state_nxt = c_IDLE;
                        if (w_rxs) begin
                            w_data_out_nxt = r_shift;
                            w_valid_nxt    = 1'b1;
`ifdef UART_RX_PARITY_EN
                            w_perr_nxt     = (^r_shift) ^ r_par_bit;
`endif
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != c_IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    // Parity is not received in this build; the flops are left unread
    assign parity_err = 1'b0;
    logic w_unused;
    assign w_unused = r_parity_err ^ r_par_bit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Drives hand-built serial frames
//            from a vector table and a few directed sequences (glitch,
//            back-to-back, reset mid-frame, sustained break).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int OS   = 16;   // ticks per bit
    localparam int TDIV = 4;    // clk cycles per sample_tick

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_tick = 1'b0;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Free-running tick: one clk-wide pulse every TDIV cycles
    logic [1:0] div = 2'd0;
    always @(posedge clk) begin
        div         <= div + 2'd1;
        sample_tick <= (div == 2'd3);
    end

    // Monitor: running totals of pulse cycles, sampled away from the edge
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_coinc = 0, n_vbusy = 0;
    logic [7:0] vlog[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                n_valid++;
                vlog.push_back(data_out);
                if (busy)       n_vbusy++;
                if (parity_err) n_coinc++;
            end
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
        end
    end

    int n_pass = 0, n_total = 0;
    int b_valid, b_ferr, b_perr, b_coinc, b_vbusy, b_log;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic snap();
        b_valid = n_valid; b_ferr = n_ferr; b_perr = n_perr;
        b_coinc = n_coinc; b_vbusy = n_vbusy; b_log = vlog.size();
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TDIV) @(negedge clk);
    endtask

    // One frame: start, data LSB-first, optional parity, stop of given length
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic pflip, input int stop_len);
        rx = 1'b0; wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; wait_ticks(OS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ pflip; wait_ticks(OS);
`else
        if (pflip) rx = 1'b1;
`endif
        rx = stop_b; wait_ticks(stop_len);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        int         nvalid;
        int         nferr;
        int         nperr;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] e0, e1;
        logic [7:0] d5a;
        // data, stop, pflip, valid, ferr, perr, expected data_out
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h11, 1'b1, 1'b0, 1, 0, 0, 8'h11};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'h11};
        vecs[3] = '{8'h80, 1'b1, 1'b0, 1, 0, 0, 8'h80};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1, 0, 0, 8'h01};
`ifdef UART_RX_PARITY_EN
        vecs[5] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 1, 0, 1, 8'hA5};
`else
        vecs[5] = '{8'h6E, 1'b1, 1'b0, 1, 0, 0, 8'h6E};
        vecs[6] = '{8'h7F, 1'b1, 1'b0, 1, 0, 0, 8'h7F};
`endif

        rst = 1'b1; rx = 1'b1;
        repeat (6) @(negedge clk);
        check("reset data_out",   32'(data_out),   32'h0);
        check("reset data_valid", 32'(data_valid), 32'h0);
        check("reset frame_err",  32'(frame_err),  32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        check("reset busy",       32'(busy),       32'h0);
        rst = 1'b0;
        wait_ticks(2 * OS);

        // Table-driven frames; a bad stop bit is held low for 12 ticks only
        for (int v = 0; v < 7; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].pflip,
                       vecs[v].stop ? OS : 12);
            wait_ticks(2 * OS);
            check($sformatf("vec%0d valid count", v), 32'(n_valid - b_valid), 32'(vecs[v].nvalid));
            check($sformatf("vec%0d ferr count", v),  32'(n_ferr - b_ferr),   32'(vecs[v].nferr));
            check($sformatf("vec%0d perr count", v),  32'(n_perr - b_perr),   32'(vecs[v].nperr));
            check($sformatf("vec%0d perr with valid", v), 32'(n_coinc - b_coinc), 32'(vecs[v].nperr));
            check($sformatf("vec%0d data_out", v),    32'(data_out),          32'(vecs[v].exp_out));
            check($sformatf("vec%0d busy at valid", v), 32'(n_vbusy - b_vbusy), 32'h0);
            check($sformatf("vec%0d busy idle", v),   32'(busy),              32'h0);
        end

        // Start glitch shorter than half a bit
        snap();
        rx = 1'b0; wait_ticks(2);
        check("glitch busy high", 32'(busy), 32'h1);
        wait_ticks(2);
        rx = 1'b1; wait_ticks(8);
        check("glitch busy low", 32'(busy), 32'h0);
        check("glitch pulses", 32'((n_valid - b_valid) + (n_ferr - b_ferr) + (n_perr - b_perr)), 32'h0);
        check("glitch data_out", 32'(data_out), 32'(vecs[6].exp_out));
        wait_ticks(OS);

        // Back-to-back frames with no idle gap
        snap();
        send_frame(8'h00, 1'b1, 1'b0, OS);
        send_frame(8'hFF, 1'b1, 1'b0, OS);
        wait_ticks(2 * OS);
        e0 = (vlog.size() > b_log)     ? vlog[b_log]     : 8'hxx;
        e1 = (vlog.size() > b_log + 1) ? vlog[b_log + 1] : 8'hxx;
        check("b2b valid count", 32'(n_valid - b_valid), 32'h2);
        check("b2b first byte",  32'(e0), 32'h00);
        check("b2b second byte", 32'(e1), 32'hFF);
        check("b2b ferr count",  32'(n_ferr - b_ferr), 32'h0);

        // Reset during bit 3 of 0x5A, then a normal 0xC3
        snap();
        d5a = 8'h5A;
        rx = 1'b0; wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            rx = d5a[i]; wait_ticks(OS);
        end
        rx = d5a[3]; wait_ticks(OS / 2);
        check("midframe busy", 32'(busy), 32'h1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; rx = 1'b1;
        check("after reset data_out", 32'(data_out), 32'h0);
        check("after reset busy",     32'(busy),     32'h0);
        wait_ticks(2 * OS);
        check("aborted frame pulses", 32'((n_valid - b_valid) + (n_ferr - b_ferr)), 32'h0);
        snap();
        send_frame(8'hC3, 1'b1, 1'b0, OS);
        wait_ticks(2 * OS);
        check("post-reset valid count", 32'(n_valid - b_valid), 32'h1);
        check("post-reset data_out",    32'(data_out), 32'hC3);

        // Sustained break of 30 bit periods, then idle high
        snap();
        rx = 1'b0; wait_ticks(30 * OS);
        rx = 1'b1; wait_ticks(12 * OS);
`ifdef UART_RX_PARITY_EN
        check("break ferr count",  32'(n_ferr - b_ferr),   32'h2);
        check("break valid count", 32'(n_valid - b_valid), 32'h1);
        check("break data_out",    32'(data_out),          32'h00);
`else
        check("break ferr count",  32'(n_ferr - b_ferr),   32'h3);
        check("break valid count", 32'(n_valid - b_valid), 32'h1);
        check("break data_out",    32'(data_out),          32'hFF);
`endif
        check("break busy idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
